mips_multicycle_ctrl: RTL and testbench

Multicycle control FSM for the MIPS datapath. It sequences fetch, decode, execute, memory and writeback over the shared ALU, register file, memory port and immediate extender. It drives every datapath mux select and write strobe, including the extender mode select. It stalls on a single-bit memory ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 57 +++++
 rtl/mips_opcode_decode.sv | 25 ++
 rtl/mips_multicycle_ctrl.sv | 159 +++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle controller: FSM states, opcodes,
// datapath select codes and the instruction classes produced by the opcode decoder.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OPC   = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        IC_RTYPE,
        IC_LOAD,
        IC_STORE,
        IC_BRANCH,
        IC_IMM,
        IC_JUMP,
        IC_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/mips_opcode_decode.sv
// Combinational opcode classifier feeding the multicycle control FSM.
// is_logical_imm flags andi/ori, whose immediates may be zero-extended.
module mips_opcode_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    output instr_class_t iclass,
    output logic         is_logical_imm
);

    always_comb begin
        case (opcode)
            OP_RTYPE:                         iclass = IC_RTYPE;
            OP_LW:                            iclass = IC_LOAD;
            OP_SW:                            iclass = IC_STORE;
            OP_BEQ, OP_BNE:                   iclass = IC_BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: iclass = IC_IMM;
            OP_J:                             iclass = IC_JUMP;
            default:                          iclass = IC_ILLEGAL;
        endcase
    end

    assign is_logical_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore decode of state, except FETCH write enables gated by mem_ready.
// Define IMM_ZERO_EXT_EN to zero-extend andi/ori immediates via ext_sel in IEXEC.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       reg_write,
    output logic       branch_ne,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       ext_sel,
    output logic       err,
    output logic [3:0] state
);

    state_t       cur_state, next_state;
    instr_class_t iclass;
    logic         is_logical_imm;
    logic         err_q;

    mips_opcode_decode u_decode (
        .opcode         (opcode),
        .iclass         (iclass),
        .is_logical_imm (is_logical_imm)
    );

`ifndef IMM_ZERO_EXT_EN
    logic unused_is_logical_imm;
    assign unused_is_logical_imm = is_logical_imm;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= S_IDLE;
            err_q     <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (next_state == S_TRAP)
                err_q <= 1'b1;
        end
    end

    // NOTE: next_state defaults to cur_state first so no path through the case infers a latch.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (iclass)
                    IC_RTYPE:           next_state = S_EXEC;
                    IC_LOAD, IC_STORE:  next_state = S_MEMADR;
                    IC_BRANCH:          next_state = S_BRANCH;
                    IC_IMM:             next_state = S_IEXEC;
                    IC_JUMP:            next_state = S_JUMP;
                    default:            next_state = S_TRAP;
                endcase
            end
            S_MEMADR: next_state = (iclass == IC_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWR:  if (mem_ready) next_state = S_FETCH;
            S_EXEC:   next_state = S_RWB;
            S_IEXEC:  next_state = S_IWB;
            S_MEMWB, S_RWB, S_BRANCH, S_IWB, S_JUMP: next_state = S_FETCH;
            S_TRAP:   next_state = S_TRAP;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        branch_ne     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        ext_sel       = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                branch_ne     = opcode[0];
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OPC;
`ifdef IMM_ZERO_EXT_EN
                ext_sel   = is_logical_imm;
`endif
            end
            S_IWB:  reg_write = 1'b1;
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign err   = err_q;
    assign state = cur_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed vector table, corner-case
// sequences and randomized instruction streams against an instruction-level model.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic       reg_write, branch_ne, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       ext_sel, err;
    logic [3:0] state;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .reg_write     (reg_write),
        .branch_ne     (branch_ne),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .ext_sel       (ext_sel),
        .err           (err),
        .state         (state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
        logic reg_write, branch_ne, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic ext_sel, err;
    } outs_t;

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
        logic [4:0] flags;  // {ir_write, pc_write, pc_write_cond, branch_ne, mem_read}
        logic [1:0] aluop;
    } vec_t;

    typedef struct {
        logic [3:0] st;
        logic       mr;
    } step_t;

    int    vectors = 0;
    int    miscompares = 0;
    step_t steps[$];
    vec_t  tbl[11];
    logic [5:0] legal_ops[10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                  6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b000010};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (state=%0d)", name, act, exp, state);
        end
    endtask

    function automatic outs_t actual();
        return '{state, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                 reg_write, branch_ne, reg_dst, mem_to_reg, alu_src_a,
                 alu_src_b, alu_op, pc_source, ext_sel, err};
    endfunction

    // Expected outputs straight from the per-state output lists of the controller.
    function automatic outs_t ref_out(input logic [3:0] st, input logic [5:0] op, input logic mr);
        outs_t o;
        o = '0;
        o.st = st;
        case (st)
            4'd1:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
            4'd2:  o.alu_src_b = 2'b11;
            4'd3:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            4'd4:  begin o.mem_read = 1; o.i_or_d = 1; end
            4'd5:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            4'd6:  begin o.mem_write = 1; o.i_or_d = 1; end
            4'd7:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            4'd8:  begin o.reg_write = 1; o.reg_dst = 1; end
            4'd9:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1;
                         o.pc_source = 2'b01; o.branch_ne = op[0]; end
            4'd10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 2'b11;
`ifdef IMM_ZERO_EXT_EN
                         o.ext_sel = (op == 6'b001100) || (op == 6'b001101);
`endif
                   end
            4'd11: o.reg_write = 1;
            4'd12: begin o.pc_write = 1; o.pc_source = 2'b10; end
            4'd13: o.err = 1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic push(input logic [3:0] st, input logic mr);
        step_t s;
        s.st = st;
        s.mr = mr;
        steps.push_back(s);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Cycle-by-cycle state walk of one instruction, with wf/wm not-ready cycles in fetch/memory.
    task automatic build(input logic [5:0] op, input int wf, input int wm);
        for (int i = 0; i < wf; i++) push(4'd1, 1'b0);
        push(4'd1, 1'b1);
        push(4'd2, rbit());
        case (op)
            6'b000000: begin push(4'd7, rbit()); push(4'd8, rbit()); end
            6'b100011: begin
                push(4'd3, rbit());
                for (int i = 0; i < wm; i++) push(4'd4, 1'b0);
                push(4'd4, 1'b1);
                push(4'd5, rbit());
            end
            6'b101011: begin
                push(4'd3, rbit());
                for (int i = 0; i < wm; i++) push(4'd6, 1'b0);
                push(4'd6, 1'b1);
            end
            6'b000100, 6'b000101: push(4'd9, rbit());
            6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
                push(4'd10, rbit());
                push(4'd11, rbit());
            end
            6'b000010: push(4'd12, rbit());
            default:   push(4'd13, rbit());
        endcase
    endtask

    task automatic run_steps(input string name);
        while (steps.size() > 0) begin
            step_t s;
            s = steps.pop_front();
            mem_ready = s.mr;
            @(negedge clk);
            check(name, 32'(actual()), 32'(ref_out(s.st, opcode, s.mr)));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("reset_async", 32'(actual()), 32'h0);
        @(posedge clk);
        #1;
        check("reset_hold", 32'(actual()), 32'h0);
        reset_n = 1'b1;
        push(4'd0, 1'b1);
        run_steps("idle_after_reset");
    endtask

    initial begin
        tbl[0]  = '{1'b0, 6'b000101, 1'b1, 4'd0,  5'b00000, 2'b00};
        tbl[1]  = '{1'b1, 6'b000101, 1'b1, 4'd0,  5'b00000, 2'b00};
        tbl[2]  = '{1'b1, 6'b000101, 1'b1, 4'd1,  5'b11001, 2'b00};
        tbl[3]  = '{1'b1, 6'b000101, 1'b1, 4'd2,  5'b00000, 2'b00};
        tbl[4]  = '{1'b1, 6'b000101, 1'b1, 4'd9,  5'b00110, 2'b01};
        tbl[5]  = '{1'b1, 6'b000101, 1'b0, 4'd1,  5'b00001, 2'b00};
        tbl[6]  = '{1'b1, 6'b000101, 1'b0, 4'd1,  5'b00001, 2'b00};
        tbl[7]  = '{1'b1, 6'b000101, 1'b1, 4'd1,  5'b11001, 2'b00};
        tbl[8]  = '{1'b1, 6'b000010, 1'b1, 4'd2,  5'b00000, 2'b00};
        tbl[9]  = '{1'b1, 6'b000010, 1'b0, 4'd12, 5'b01000, 2'b00};
        tbl[10] = '{1'b1, 6'b000010, 1'b1, 4'd1,  5'b11001, 2'b00};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) begin
            reset_n   = tbl[i].rst;
            opcode    = tbl[i].op;
            mem_ready = tbl[i].mr;
            @(negedge clk);
            check($sformatf("table[%0d]", i),
                  32'({state, ir_write, pc_write, pc_write_cond, branch_ne, mem_read, alu_op}),
                  32'({tbl[i].st, tbl[i].flags, tbl[i].aluop}));
            @(posedge clk);
            #1;
        end

        // lw with two not-ready cycles in MEMRD: seven cycles back to FETCH
        do_reset();
        opcode = 6'b100011;
        build(6'b100011, 0, 2);
        run_steps("lw_wait");
        check("lw_7_cycles", 32'(state), 32'd1);

        // sw interrupted by reset while waiting in MEMWR
        do_reset();
        opcode = 6'b101011;
        push(4'd1, 1'b1); push(4'd2, 1'b1); push(4'd3, 1'b1);
        run_steps("sw_pre");
        mem_ready = 1'b0;
        #1;
        check("sw_wait_mem_write", 32'({state, mem_write}), 32'({4'd6, 1'b1}));
        reset_n = 1'b0;
        #1;
        check("sw_reset_drop", 32'({state, mem_write}), 32'({4'd0, 1'b0}));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd2, 1'b1);
        run_steps("sw_refetch");

        // immediate extender mode for ori and addi
        do_reset();
        opcode = 6'b001101;
        build(6'b001101, 0, 0);
        run_steps("ori");
        opcode = 6'b001000;
        build(6'b001000, 0, 0);
        run_steps("addi");

        // randomized legal instruction stream with random memory stalls
        do_reset();
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            int wf, wm;
            op = legal_ops[$urandom_range(0, 9)];
            wf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            wm = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            opcode = op;
            build(op, wf, wm);
            run_steps($sformatf("random_op%b", op));
        end

        // illegal opcode: TRAP is terminal and err holds until reset
        opcode = 6'b111111;
        build(6'b111111, 1, 0);
        for (int i = 0; i < 99; i++) push(4'd13, rbit());
        run_steps("trap");
        do_reset();
        push(4'd1, 1'b1);
        run_steps("after_trap");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
